serial_adder_sched: RTL and testbench
=====================================

Name: serial_adder_sched

Overview:
- Two-requester scheduler that time-shares one bit-serial adder (ports clk, rst, a, b, stream).
- Accepts parallel W-bit operand pairs and arbitrates round-robin between the requesters.
- Clears the adder carry, shifts the operands LSB-first into the adder, and reassembles the serial stream into a W-bit sum plus carry-out.
- Returns the result on a valid/ready response port tagged with the requester ID.

Parameters:
- W, 8, operand/sum width in bits (2..32).
- SA_LAT, 0, adder output latency in cycles: 0 = stream valid in the same cycle as a/b; 1 = stream registered, valid one cycle later.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operand pair.
- req0_ready  out  1  requester 0 pair accepted this cycle.
- req0_a  in  W  requester 0 operand A.
- req0_b  in  W  requester 0 operand B.
- req1_valid, req1_ready, req1_a, req1_b  same as requester 0, for requester 1.
- sa_rst  out  1  drives the adder rst; clears the adder carry.
- sa_a  out  1  serial operand bit A to the adder.
- sa_b  out  1  serial operand bit B to the adder.
- sa_stream  in  1  serial sum bit from the adder.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts the result.
- resp_id  out  1  requester that owns the result.
- resp_sum  out  W  sum of A and B, modulo 2^W.
- resp_cout  out  1  carry-out of the addition.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset values: state IDLE; all outputs 0; last_grant = 1, so requester 0 wins the first tie. sa_rst = rst | (state==CLR).
- States: IDLE, CLR, SHIFT, RESP.
- IDLE, arbitration:
  - If exactly one reqN_valid is high, grant that requester.
  - If both are high, grant the requester that is not last_grant.
  - In the grant cycle: assert reqN_ready (combinational, only in IDLE); latch A, B and the ID; update last_grant; go to CLR.
  - The non-granted requester's ready stays 0.
- CLR (1 cycle): sa_rst = 1, sa_a = sa_b = 0; clear cnt and the result shift register; go to SHIFT.
- SHIFT (W+1+SA_LAT cycles, cnt = 0..W+SA_LAT):
  - Drive sa_a = A[cnt], sa_b = B[cnt] for cnt < W; drive 0 for cnt >= W. The zero pad bit at index W yields the carry-out.
  - When cnt >= SA_LAT, capture sa_stream into result bit (cnt - SA_LAT).
  - Bits 0..W-1 form resp_sum; bit W forms resp_cout.
  - After the cycle with cnt = W+SA_LAT, go to RESP.
- RESP:
  - resp_valid = 1 with resp_id, resp_sum and resp_cout held stable.
  - Go to IDLE in the cycle where resp_valid & resp_ready; no new request is accepted in that cycle.
  - Backpressure is unlimited; outputs hold until accepted.
- Latency: request accepted at cycle t → resp_valid first high at t + W + 3 + SA_LAT (W=8, SA_LAT=0: t+11).
- Throughput: one addition per W + 4 + SA_LAT cycles when resp_ready is held high.
- Outside SHIFT: sa_a = sa_b = 0. Operand inputs are ignored outside the grant cycle; changing them mid-operation has no effect.
- Reset asserted in any state: next cycle is IDLE with reset values; the in-flight result is discarded and no response is issued. sa_rst is high for the whole reset.
- A reqN_valid that stays high after its grant is treated as a new request. With both requesters continuously valid, grants alternate 0,1,0,1.

Test Plan:
- Single add, W=8, SA_LAT=0: req0 A=0xA5, B=0x3C → resp_sum=0xE1, resp_cout=0, resp_id=0, resp_valid at accept+11; sa_rst high exactly 1 cycle after accept.
- Overflow: req1 A=0xFF, B=0x01 → resp_sum=0x00, resp_cout=1, resp_id=1. Also A=0xFF, B=0xFF → resp_sum=0xFE, resp_cout=1.
- Arbitration: after reset, both valid continuously with distinct operands → grant order 0,1,0,1. Only one ready per grant, and each ready only in an IDLE cycle.
- Backpressure: resp_ready low for 20 cycles in RESP → resp_valid and data held constant, both reqN_ready stay 0; raise resp_ready → IDLE next cycle, then the next grant.
- Reset mid-SHIFT: assert rst at cnt=4 for 1 cycle → busy=0 and resp_valid=0 next cycle, no response issued; a following req0 of 0x10+0x20 returns 0x30.
- SA_LAT=1 with a registered-output adder model: 0x7F + 0x01 → resp_sum=0x80, resp_cout=0, resp_valid at accept+12.

Source files
------------

// File: rtl/serial_adder_sched.sv
// serial_adder_sched: round-robin scheduler sharing one bit-serial adder between two requesters.
// Latency accept->resp_valid = W+3+SA_LAT cycles; the response holds under unlimited resp_ready backpressure and no grant is issued until it is taken.
module serial_adder_sched #(
   parameter int W      = 8,
   parameter int SA_LAT = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [W-1:0] req0_a,
   input  logic [W-1:0] req0_b,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [W-1:0] req1_a,
   input  logic [W-1:0] req1_b,
   output logic         sa_rst,
   output logic         sa_a,
   output logic         sa_b,
   input  logic         sa_stream,
   output logic         resp_valid,
   input  logic         resp_ready,
   output logic         resp_id,
   output logic [W-1:0] resp_sum,
   output logic         resp_cout,
   output logic         busy
);

   localparam int CW = 6;
   localparam logic [CW-1:0] CNT_LAST = CW'(W + SA_LAT);

   typedef enum logic [1:0] {IDLE, CLR, SHIFT, RESP} state_t;

   state_t        state, state_nxt;
   logic [W-1:0]  opa, opa_nxt;
   logic [W-1:0]  opb, opb_nxt;
   logic [W:0]    res, res_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          owner, owner_nxt;
   logic          last_grant, last_grant_nxt;
   logic          grant0, grant1;

   // On a tie the requester that did not win last time gets the adder.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (state == IDLE && !rst) begin
         if (req0_valid && (!req1_valid || last_grant))
            grant0 = 1'b1;
         else if (req1_valid)
            grant1 = 1'b1;
      end
   end

   always_comb begin
      state_nxt      = state;
      opa_nxt        = opa;
      opb_nxt        = opb;
      res_nxt        = res;
      cnt_nxt        = cnt;
      owner_nxt      = owner;
      last_grant_nxt = last_grant;
      sa_a           = 1'b0;
      sa_b           = 1'b0;
      case (state)
         IDLE: begin
            if (grant0 || grant1) begin
               opa_nxt        = grant1 ? req1_a : req0_a;
               opb_nxt        = grant1 ? req1_b : req0_b;
               owner_nxt      = grant1;
               last_grant_nxt = grant1;
               state_nxt      = CLR;
            end
         end
         CLR: begin
            cnt_nxt   = '0;
            res_nxt   = '0;
            state_nxt = SHIFT;
         end
         SHIFT: begin
            // Operands shift right so zeros pad the tail; the pad bit yields the carry-out.
            sa_a    = opa[0];
            sa_b    = opb[0];
            opa_nxt = opa >> 1;
            opb_nxt = opb >> 1;
            cnt_nxt = cnt + CW'(1);
            if (int'(cnt) >= SA_LAT)
               res_nxt = {sa_stream, res[W:1]};
            if (cnt == CNT_LAST)
               state_nxt = RESP;
         end
         RESP: begin
            if (resp_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         opa        <= '0;
         opb        <= '0;
         res        <= '0;
         cnt        <= '0;
         owner      <= 1'b0;
         last_grant <= 1'b1;
      end else begin
         state      <= state_nxt;
         opa        <= opa_nxt;
         opb        <= opb_nxt;
         res        <= res_nxt;
         cnt        <= cnt_nxt;
         owner      <= owner_nxt;
         last_grant <= last_grant_nxt;
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign sa_rst     = rst | (state == CLR);
   assign resp_valid = (state == RESP);
   assign resp_id    = owner;
   assign resp_sum   = res[W-1:0];
   assign resp_cout  = res[W];
   assign busy       = (state != IDLE);

endmodule

// File: tb/tb_serial_adder_sched.sv
// Bench for serial_adder_sched: dut0 uses a combinational adder model (SA_LAT=0), dut1 a registered one (SA_LAT=1).
module tb_serial_adder_sched;
   localparam int W = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic         req0_valid, req0_ready, req1_valid, req1_ready;
   logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
   logic         sa_rst, sa_a, sa_b, sa_stream;
   logic         resp_valid, resp_ready, resp_id, resp_cout, busy;
   logic [W-1:0] resp_sum;

   logic         l_req0_valid, l_req0_ready, l_req1_valid, l_req1_ready;
   logic [W-1:0] l_req0_a, l_req0_b, l_req1_a, l_req1_b;
   logic         l_sa_rst, l_sa_a, l_sa_b, l_sa_stream;
   logic         l_resp_valid, l_resp_ready, l_resp_id, l_resp_cout, l_busy;
   logic [W-1:0] l_resp_sum;

   serial_adder_sched #(.W(W), .SA_LAT(0)) dut0 (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
      .sa_rst(sa_rst), .sa_a(sa_a), .sa_b(sa_b), .sa_stream(sa_stream),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
      .resp_sum(resp_sum), .resp_cout(resp_cout), .busy(busy));

   serial_adder_sched #(.W(W), .SA_LAT(1)) dut1 (
      .clk(clk), .rst(rst),
      .req0_valid(l_req0_valid), .req0_ready(l_req0_ready), .req0_a(l_req0_a), .req0_b(l_req0_b),
      .req1_valid(l_req1_valid), .req1_ready(l_req1_ready), .req1_a(l_req1_a), .req1_b(l_req1_b),
      .sa_rst(l_sa_rst), .sa_a(l_sa_a), .sa_b(l_sa_b), .sa_stream(l_sa_stream),
      .resp_valid(l_resp_valid), .resp_ready(l_resp_ready), .resp_id(l_resp_id),
      .resp_sum(l_resp_sum), .resp_cout(l_resp_cout), .busy(l_busy));

   // Serial adder models: carry cleared by sa_rst; the second one registers its sum bit.
   logic car0, car1, sq1;
   always_ff @(posedge clk) begin
      if (sa_rst) car0 <= 1'b0;
      else        car0 <= (sa_a & sa_b) | (car0 & (sa_a ^ sa_b));
   end
   assign sa_stream = sa_a ^ sa_b ^ car0;

   always_ff @(posedge clk) begin
      if (l_sa_rst) begin
         car1 <= 1'b0;
         sq1  <= 1'b0;
      end else begin
         car1 <= (l_sa_a & l_sa_b) | (car1 & (l_sa_a ^ l_sa_b));
         sq1  <= l_sa_a ^ l_sa_b ^ car1;
      end
   end
   assign l_sa_stream = sq1;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   always_ff @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic         id;
      logic [W-1:0] sum;
      logic         cout;
      int           cyc;
   } rec_t;

   rec_t exp_q[$];
   rec_t obs_q[$];
   int   rise_cyc = 0;
   logic vld_d = 1'b0;
   logic sa_rst_acc = 1'b0;
   logic [W:0] s0;

   // Inputs change on the falling edge; this samples them 2 time units later.
   always @(negedge clk) begin
      #2;
      if (!rst) begin
         if (req0_valid && req0_ready) begin
            s0 = {1'b0, req0_a} + {1'b0, req0_b};
            exp_q.push_back('{1'b0, s0[W-1:0], s0[W], cyc});
            sa_rst_acc = sa_rst;
         end
         if (req1_valid && req1_ready) begin
            s0 = {1'b0, req1_a} + {1'b0, req1_b};
            exp_q.push_back('{1'b1, s0[W-1:0], s0[W], cyc});
            sa_rst_acc = sa_rst;
         end
         if (resp_valid && !vld_d) rise_cyc = cyc;
         if (resp_valid && resp_ready)
            obs_q.push_back('{resp_id, resp_sum, resp_cout, rise_cyc});
      end
      vld_d = resp_valid;
   end

   task automatic send(input bit id, input logic [W-1:0] a, input logic [W-1:0] b, output bit ok);
      ok = 1'b0;
      @(negedge clk);
      if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
      else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
      for (int i = 0; i < 40; i++) begin
         #3;
         if (id ? req1_ready : req0_ready) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      @(negedge clk);
      if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
   endtask

   task automatic wait_obs(input int lim, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < lim; i++) begin
         @(negedge clk); #3;
         if (obs_q.size() > 0) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req0_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h02;
      req1_valid = 1'b1; req1_a = 8'h03; req1_b = 8'h04;
      resp_ready = 1'b1;
      repeat (2) @(negedge clk);
      #3;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
      checks++; if ({req0_ready, req1_ready} !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", {req0_ready, req1_ready}); end
      checks++; if (sa_rst !== 1'b1) begin failures++; $display("FAIL reset_sa_rst got=%b exp=1", sa_rst); end
      checks++; if ({resp_sum, resp_cout, resp_id, sa_a, sa_b} !== 11'd0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", {resp_sum, resp_cout, resp_id, sa_a, sa_b}); end
      @(negedge clk);
      rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
      #3;
      checks++; if (sa_rst !== 1'b0) begin failures++; $display("FAIL reset_release_sa_rst got=%b exp=0", sa_rst); end
   endtask

   task automatic test_single();
      bit ok;
      rec_t o, e;
      resp_ready = 1'b1;
      send(1'b0, 8'hA5, 8'h3C, ok);
      checks++; if (!ok) begin failures++; $display("FAIL single_accept got=timeout exp=ready"); end
      #3;
      checks++; if (sa_rst !== 1'b1) begin failures++; $display("FAIL single_sa_rst_clr got=%b exp=1", sa_rst); end
      checks++; if (sa_rst_acc !== 1'b0) begin failures++; $display("FAIL single_sa_rst_accept got=%b exp=0", sa_rst_acc); end
      @(negedge clk); #3;
      checks++; if (sa_rst !== 1'b0) begin failures++; $display("FAIL single_sa_rst_shift got=%b exp=0", sa_rst); end
      wait_obs(30, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL single_resp got=timeout exp=response"); end
      else begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         checks++; if (o.sum !== 8'hE1) begin failures++; $display("FAIL single_sum got=%h exp=e1", o.sum); end
         checks++; if ({o.id, o.cout} !== {e.id, e.cout}) begin failures++; $display("FAIL single_id_cout got=%b%b exp=%b%b", o.id, o.cout, e.id, e.cout); end
         checks++; if (o.cyc - e.cyc !== 11) begin failures++; $display("FAIL single_latency got=%0d exp=11", o.cyc - e.cyc); end
      end
   endtask

   task automatic test_overflow();
      bit ok;
      rec_t o, e;
      logic         vid [2] = '{1'b1, 1'b0};
      logic [W-1:0] va  [2] = '{8'hFF, 8'hFF};
      logic [W-1:0] vb  [2] = '{8'h01, 8'hFF};
      logic [W-1:0] vs  [2] = '{8'h00, 8'hFE};
      for (int k = 0; k < 2; k++) begin
         send(vid[k], va[k], vb[k], ok);
         wait_obs(30, ok);
         checks++;
         if (!ok) begin failures++; $display("FAIL ovf%0d_resp got=timeout exp=response", k); end
         else begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++; if (o.sum !== vs[k] || o.sum !== e.sum) begin failures++; $display("FAIL ovf%0d_sum got=%h exp=%h", k, o.sum, vs[k]); end
            checks++; if (o.cout !== 1'b1) begin failures++; $display("FAIL ovf%0d_cout got=%b exp=1", k, o.cout); end
            checks++; if (o.id !== vid[k]) begin failures++; $display("FAIL ovf%0d_id got=%b exp=%b", k, o.id, vid[k]); end
         end
      end
   endtask

   task automatic test_arbitration();
      int n = 0;
      int prev = 0;
      logic g0, g1;
      rec_t o, e;
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      exp_q.delete(); obs_q.delete();
      resp_ready = 1'b1;
      req0_a = 8'h10; req0_b = 8'h01; req1_a = 8'h20; req1_b = 8'h02;
      req0_valid = 1'b1; req1_valid = 1'b1;
      for (int i = 0; i < 200 && n < 4; i++) begin
         #3;
         g0 = req0_ready; g1 = req1_ready;
         if (g0 || g1) begin
            checks++;
            if ((g0 && g1) || busy !== 1'b0) begin failures++; $display("FAIL arb_ready got=%b%b busy=%b exp=onehot_idle", g0, g1, busy); end
            n++;
         end
         @(negedge clk);
         if (g0) req0_a = req0_a + 8'h31;
         if (g1) req1_b = req1_b + 8'h47;
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      checks++; if (n !== 4) begin failures++; $display("FAIL arb_grants got=%0d exp=4", n); end
      for (int i = 0; i < 100 && obs_q.size() < 4; i++) @(negedge clk);
      checks++;
      if (obs_q.size() < 4 || exp_q.size() < 4) begin failures++; $display("FAIL arb_resp got=%0d exp=4", obs_q.size()); end
      else begin
         for (int k = 0; k < 4; k++) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            checks++; if (o.id !== k[0]) begin failures++; $display("FAIL arb_order%0d got=%b exp=%b", k, o.id, k[0]); end
            checks++; if ({o.sum, o.cout} !== {e.sum, e.cout}) begin failures++; $display("FAIL arb_data%0d got=%h exp=%h", k, {o.cout, o.sum}, {e.cout, e.sum}); end
            if (k > 0) begin
               checks++; if (e.cyc - prev !== 12) begin failures++; $display("FAIL arb_rate%0d got=%0d exp=12", k, e.cyc - prev); end
            end
            prev = e.cyc;
         end
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      rec_t o, e;
      resp_ready = 1'b0;
      send(1'b0, 8'h12, 8'h34, ok);
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk); #3;
         if (resp_valid) begin ok = 1'b1; break; end
      end
      checks++; if (!ok) begin failures++; $display("FAIL bp_valid got=timeout exp=resp_valid"); end
      @(negedge clk);
      req0_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h02;
      req1_valid = 1'b1; req1_a = 8'h40; req1_b = 8'h05;
      for (int i = 0; i < 20; i++) begin
         #3;
         checks++;
         if (resp_valid !== 1'b1 || resp_sum !== 8'h46 || resp_cout !== 1'b0 || resp_id !== 1'b0 || req0_ready || req1_ready) begin
            failures++;
            $display("FAIL bp_hold%0d got=v%b s%h c%b i%b r%b%b exp=v1 s46 c0 i0 r00", i, resp_valid, resp_sum, resp_cout, resp_id, req0_ready, req1_ready);
         end
         @(negedge clk);
      end
      resp_ready = 1'b1;
      #3;
      checks++; if ({req0_ready, req1_ready} !== 2'b00) begin failures++; $display("FAIL bp_handshake_ready got=%b exp=00", {req0_ready, req1_ready}); end
      @(negedge clk); #3;
      checks++; if ({busy, req0_ready, req1_ready} !== 3'b001) begin failures++; $display("FAIL bp_next_grant got=%b exp=001", {busy, req0_ready, req1_ready}); end
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0;
      checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL bp_resp got=none exp=response"); end
      else begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         checks++; if ({o.id, o.sum, o.cout} !== {e.id, e.sum, e.cout}) begin failures++; $display("FAIL bp_data got=%h exp=%h", {o.id, o.sum, o.cout}, {e.id, e.sum, e.cout}); end
      end
      wait_obs(30, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL bp_second got=timeout exp=response"); end
      else begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         checks++; if (o.id !== 1'b1 || o.sum !== 8'h45 || o.sum !== e.sum) begin failures++; $display("FAIL bp_second_data got=%b/%h exp=1/45", o.id, o.sum); end
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      rec_t o, e;
      resp_ready = 1'b1;
      send(1'b0, 8'h55, 8'h0F, ok);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #3;
      checks++; if ({sa_rst, busy} !== 2'b11) begin failures++; $display("FAIL rmid_during got=%b exp=11", {sa_rst, busy}); end
      @(negedge clk);
      rst = 1'b0;
      #3;
      checks++; if ({busy, resp_valid} !== 2'b00) begin failures++; $display("FAIL rmid_after got=%b exp=00", {busy, resp_valid}); end
      checks++;
      if (exp_q.size() != 1) begin failures++; $display("FAIL rmid_accept got=%0d exp=1", exp_q.size()); end
      exp_q.delete();
      repeat (20) @(negedge clk);
      checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL rmid_no_resp got=%0d exp=0", obs_q.size()); end
      obs_q.delete();
      send(1'b0, 8'h10, 8'h20, ok);
      wait_obs(30, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL rmid_next got=timeout exp=response"); end
      else begin
         o = obs_q.pop_front(); e = exp_q.pop_front();
         checks++; if (o.sum !== 8'h30 || {o.id, o.cout} !== {e.id, e.cout}) begin failures++; $display("FAIL rmid_next_data got=%h exp=30", o.sum); end
      end
   endtask

   task automatic test_sa_lat1();
      bit ok = 1'b0;
      int acc = 0;
      int rise = 0;
      rec_t lexp[$];
      rec_t e;
      logic [W:0] s;
      l_resp_ready = 1'b1;
      @(negedge clk);
      l_req0_valid = 1'b1; l_req0_a = 8'h7F; l_req0_b = 8'h01;
      for (int i = 0; i < 20; i++) begin
         #3;
         if (l_req0_ready) begin
            ok = 1'b1; acc = cyc;
            s = {1'b0, l_req0_a} + {1'b0, l_req0_b};
            lexp.push_back('{1'b0, s[W-1:0], s[W], cyc});
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      l_req0_valid = 1'b0;
      checks++; if (!ok) begin failures++; $display("FAIL lat1_accept got=timeout exp=ready"); end
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk); #3;
         if (l_resp_valid) begin ok = 1'b1; rise = cyc; break; end
      end
      checks++;
      if (!ok || lexp.size() == 0) begin failures++; $display("FAIL lat1_resp got=timeout exp=response"); end
      else begin
         e = lexp.pop_front();
         checks++; if (rise - acc !== 12) begin failures++; $display("FAIL lat1_latency got=%0d exp=12", rise - acc); end
         checks++; if (l_resp_sum !== 8'h80 || l_resp_sum !== e.sum) begin failures++; $display("FAIL lat1_sum got=%h exp=80", l_resp_sum); end
         checks++; if ({l_resp_cout, l_resp_id} !== {e.cout, e.id}) begin failures++; $display("FAIL lat1_cout_id got=%b exp=%b", {l_resp_cout, l_resp_id}, {e.cout, e.id}); end
      end
      @(negedge clk); #3;
      checks++; if (l_busy !== 1'b0) begin failures++; $display("FAIL lat1_idle got=%b exp=0", l_busy); end
   endtask

   initial begin
      rst = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
      req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
      l_req0_valid = 1'b0; l_req1_valid = 1'b0; l_resp_ready = 1'b0;
      l_req0_a = '0; l_req0_b = '0; l_req1_a = '0; l_req1_b = '0;
      test_reset();
      test_single();
      test_overflow();
      test_arbitration();
      test_backpressure();
      test_reset_mid();
      test_sa_lat1();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
